// File: rtl/jt51_ring_loader.sv
// jt51_ring_loader: write sequencer for a jt51_sh2 circulating ring.
// Owns the ring slot counter and the shifter en/ld/din controls. Host writes
// are queued in a small in-order FIFO. Each write is injected on the
// clock-enabled cycle when its target slot sits at the ring output.
// Optional readback port, built only when JT51_RING_RDBACK_EN is defined;
// otherwise rd_busy/rd_valid/rd_data are tied to 0.
module jt51_ring_loader #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 32,
    parameter int DEPTH  = 4,
    localparam int SW    = $clog2(STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [SW-1:0]    wr_slot,
    input  logic [WIDTH-1:0] wr_data,
    output logic             sh_en,
    output logic             sh_ld,
    output logic [WIDTH-1:0] sh_din,
    input  logic [WIDTH-1:0] sh_drop,
    output logic [SW-1:0]    slot,
    input  logic             rd_req,
    input  logic [SW-1:0]    rd_slot,
    output logic             rd_busy,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [SW-1:0]    r_slot;
    logic [SW-1:0]    r_q_slot [DEPTH];
    logic [WIDTH-1:0] r_q_data [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             r_wr_ready;

    logic             w_empty;
    logic             w_push;
    logic             w_ld;
    logic [CW-1:0]    w_cnt_nxt;

    assign w_empty   = (r_cnt == '0);
    assign w_push    = wr_valid & r_wr_ready;
    // Only the FIFO head is ever compared, so writes retire strictly in order.
    assign w_ld      = cen & ~rst & ~w_empty & (r_q_slot[r_rptr] == r_slot);
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_ld);

    assign sh_en    = cen & ~rst;
    assign sh_ld    = w_ld;
    assign sh_din   = w_empty ? '0 : r_q_data[r_rptr];
    assign slot     = r_slot;
    assign wr_ready = r_wr_ready;

    // Slot counter: advances once per slot time, wraps naturally at STAGES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_slot <= '0;
        else if (cen)
            r_slot <= r_slot + SW'(1);
    end

    // FIFO storage: contents need no reset, occupancy lives in r_cnt.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_slot[r_wptr] <= wr_slot;
            r_q_data[r_wptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; ready is registered from next occupancy,
    // so a full FIFO stays closed for the cycle even if it pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_wr_ready <= 1'b1;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_ld)
                r_rptr <= r_rptr + AW'(1);
            r_cnt      <= w_cnt_nxt;
            r_wr_ready <= (w_cnt_nxt != CW'(DEPTH));
        end
    end

`ifdef JT51_RING_RDBACK_EN
    logic             r_rd_busy;
    logic             r_rd_valid;
    logic [SW-1:0]    r_rd_slot;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_cap;

    // Capture uses sh_drop directly, which is the pre-load value of the slot.
    assign w_cap = r_rd_busy & cen & (r_slot == r_rd_slot);

    // Readback: latch request when idle, capture when the slot passes by.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_busy  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_slot  <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_cap;
            if (w_cap) begin
                r_rd_data <= sh_drop;
                r_rd_busy <= 1'b0;
            end else if (rd_req && !r_rd_busy) begin
                r_rd_slot <= rd_slot;
                r_rd_busy <= 1'b1;
            end
        end
    end

    assign rd_busy  = r_rd_busy;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{rd_req, rd_slot, sh_drop};
    assign rd_busy     = 1'b0;
    assign rd_valid    = 1'b0;
    assign rd_data     = '0;
`endif

endmodule

// File: tb/tb_jt51_ring_loader.sv
// Bench for jt51_ring_loader with a behavioural jt51_sh2-style ring attached.
// Expected loads and readbacks are queued when stimulus is driven and checked
// by a monitor when the DUT produces them.
module tb_jt51_ring_loader;
    localparam int WIDTH  = 5;
    localparam int STAGES = 32;
    localparam int DEPTH  = 4;
    localparam int SW     = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cen = 1'b0;
    logic             wr_valid = 1'b0;
    logic             rd_req = 1'b0;
    logic [SW-1:0]    wr_slot = '0;
    logic [SW-1:0]    rd_slot = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_ready, sh_en, sh_ld, rd_busy, rd_valid;
    logic [WIDTH-1:0] sh_din, sh_drop, rd_data;
    logic [SW-1:0]    slot;

    typedef struct packed {
        logic [SW-1:0]    s;
        logic [WIDTH-1:0] d;
    } ld_t;

    ld_t              exp_q[$];
    logic [WIDTH-1:0] rd_q[$];
    logic [WIDTH-1:0] ring [STAGES];
    logic             ring_init = 1'b0;
    logic [SW-1:0]    exp_slot;
    logic             prev_rdv = 1'b0;
    int ntests = 0, nfail = 0;
    int cen_cnt = 0, load_cnt = 0, last_load_cen = 0;
    int cen_div = 1, phase = 0;

    jt51_ring_loader #(.WIDTH(WIDTH), .STAGES(STAGES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot), .wr_data(wr_data),
        .sh_en(sh_en), .sh_ld(sh_ld), .sh_din(sh_din), .sh_drop(sh_drop), .slot(slot),
        .rd_req(rd_req), .rd_slot(rd_slot), .rd_busy(rd_busy), .rd_valid(rd_valid),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // cen generator: every clk, or one in cen_div clks
    always @(posedge clk) begin
        #1;
        if (cen_div <= 1) cen = 1'b1;
        else begin
            cen = (phase == 0);
            phase = (phase + 1) % cen_div;
        end
    end

    // Ring model: drop is the last stage, en shifts, ld replaces the recirculated value
    assign sh_drop = ring[STAGES-1];
    always @(posedge clk) begin
        if (!ring_init) begin
            for (int i = 0; i < STAGES; i++) ring[i] <= '0;
            ring_init <= 1'b1;
        end else if (sh_en) begin
            ring[0] <= sh_ld ? sh_din : ring[STAGES-1];
            for (int i = 1; i < STAGES; i++) ring[i] <= ring[i-1];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) exp_slot <= '0;
        else if (cen) exp_slot <= exp_slot + 5'd1;
    end

    always @(posedge clk) if (cen) cen_cnt <= cen_cnt + 1;

    // Monitor: sampled mid-cycle
    always @(negedge clk) begin
        ntests++;
        if (slot !== exp_slot) begin
            nfail++; $display("FAIL slot_track got %0d want %0d", slot, exp_slot);
        end
        ntests++;
        if (sh_en !== (cen & ~rst)) begin
            nfail++; $display("FAIL sh_en got %b want %b", sh_en, cen & ~rst);
        end
        if (sh_ld === 1'b1) begin
            load_cnt++;
            last_load_cen = cen_cnt + 1;
            ntests++;
            if (!cen) begin
                nfail++; $display("FAIL ld_without_cen got 1 want 0");
            end
            ntests++;
            if (exp_q.size() == 0) begin
                nfail++; $display("FAIL unexpected_load slot %0d din %h", slot, sh_din);
            end else begin
                ld_t e;
                e = exp_q.pop_front();
                if (slot !== e.s || sh_din !== e.d) begin
                    nfail++;
                    $display("FAIL load_order got slot %0d din %h want slot %0d din %h",
                             slot, sh_din, e.s, e.d);
                end
            end
        end
        if (rd_valid === 1'b1) begin
            ntests++;
            if (prev_rdv) begin
                nfail++; $display("FAIL rd_valid_width got 2+ clk want 1");
            end
            ntests++;
            if (rd_q.size() == 0) begin
                nfail++; $display("FAIL unexpected_rd_valid data %h", rd_data);
            end else begin
                logic [WIDTH-1:0] ed;
                ed = rd_q.pop_front();
                if (rd_data !== ed) begin
                    nfail++; $display("FAIL rd_data got %h want %h", rd_data, ed);
                end
            end
        end
        prev_rdv = (rd_valid === 1'b1);
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_slot(input logic [SW-1:0] k, input bit need_cen);
        bit hit = 0;
        for (int n = 0; n < 300 && !hit; n++) begin
            step();
            if (slot === k && (!need_cen || cen)) hit = 1;
        end
        if (!hit) begin
            ntests++; nfail++; $display("FAIL wait_slot_timeout slot %0d want %0d", slot, k);
        end
    endtask

    // Presents a write and returns just after the edge that accepted it
    task automatic do_write(input logic [SW-1:0] s, input logic [WIDTH-1:0] d);
        bit ok = 0;
        ld_t e;
        wr_slot = s; wr_data = d; wr_valid = 1'b1;
        for (int n = 0; n < 400 && !ok; n++) begin
            if (wr_ready) ok = 1;
            else step();
        end
        if (!ok) begin
            ntests++; nfail++; $display("FAIL wr_ready_timeout got 0 want 1");
        end
        e.s = s; e.d = d;
        exp_q.push_back(e);
        step();
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) step();
        ntests++;
        if (exp_q.size() != 0) begin
            nfail++; $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic wait_rd();
        for (int n = 0; n < 400 && rd_q.size() != 0; n++) step();
        ntests++;
        if (rd_q.size() != 0) begin
            nfail++; $display("FAIL rd_timeout got %0d pending want 0", rd_q.size());
        end
    endtask

    task automatic test_reset();
        step(); step();
        ntests++; if (slot !== 0)      begin nfail++; $display("FAIL rst_slot got %0d want 0", slot); end
        ntests++; if (wr_ready !== 1)  begin nfail++; $display("FAIL rst_wr_ready got %b want 1", wr_ready); end
        ntests++; if (sh_en !== 0)     begin nfail++; $display("FAIL rst_sh_en got %b want 0", sh_en); end
        ntests++; if (sh_ld !== 0)     begin nfail++; $display("FAIL rst_sh_ld got %b want 0", sh_ld); end
        ntests++; if (sh_din !== 0)    begin nfail++; $display("FAIL rst_sh_din got %h want 0", sh_din); end
        ntests++; if (rd_busy !== 0)   begin nfail++; $display("FAIL rst_rd_busy got %b want 0", rd_busy); end
        ntests++; if (rd_valid !== 0)  begin nfail++; $display("FAIL rst_rd_valid got %b want 0", rd_valid); end
        ntests++; if (rd_data !== 0)   begin nfail++; $display("FAIL rst_rd_data got %h want 0", rd_data); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int lc;
        wait_slot(0, 1);
        do_write(5'd3, 5'h15);
        wr_valid = 1'b0;
        wait_slot(5'd3, 0);
        lc = load_cnt;
        ntests++; if (sh_ld !== 1)     begin nfail++; $display("FAIL single_ld got %b want 1", sh_ld); end
        ntests++; if (sh_din !== 5'h15) begin nfail++; $display("FAIL single_din got %h want 15", sh_din); end
        step();
        ntests++; if (sh_ld !== 0)     begin nfail++; $display("FAIL single_ld_width got %b want 0", sh_ld); end
        ntests++; if (load_cnt !== lc + 1) begin nfail++; $display("FAIL single_ld_count got %0d want %0d", load_cnt, lc + 1); end
        wait_slot(5'd3, 0);
        ntests++; if (sh_drop !== 5'h15) begin nfail++; $display("FAIL single_visible got %h want 15", sh_drop); end
    endtask

    task automatic test_fifo_full();
        wait_slot(0, 1);
        do_write(5'd10, 5'h01);
        do_write(5'd2,  5'h02);
        do_write(5'd7,  5'h03);
        do_write(5'd30, 5'h04);
        wr_valid = 1'b0;
        ntests++; if (wr_ready !== 0) begin nfail++; $display("FAIL full_ready got %b want 0", wr_ready); end
        wait_slot(5'd10, 0);
        ntests++; if (sh_ld !== 1 || sh_din !== 5'h01) begin nfail++; $display("FAIL full_first_ld got %b/%h want 1/01", sh_ld, sh_din); end
        ntests++; if (wr_ready !== 0) begin nfail++; $display("FAIL full_ready_at_pop got %b want 0", wr_ready); end
        step();
        ntests++; if (wr_ready !== 1) begin nfail++; $display("FAIL full_ready_after_pop got %b want 1", wr_ready); end
        wait_drain();
    endtask

    task automatic test_same_slot();
        int acc;
        wait_slot(5'd5, 1);
        do_write(5'd5, 5'h0A);
        wr_valid = 1'b0;
        acc = cen_cnt;
        wait_drain();
        ntests++;
        if (last_load_cen - acc !== STAGES) begin
            nfail++; $display("FAIL same_slot_latency got %0d want %0d", last_load_cen - acc, STAGES);
        end
    endtask

    task automatic test_cen_gating();
        int acc;
        cen_div = 3;
        step(); step(); step();
        wait_slot(0, 1);
        do_write(5'd1, 5'h07);
        wr_valid = 1'b0;
        acc = cen_cnt;
        wait_drain();
        ntests++;
        if (last_load_cen - acc !== 1) begin
            nfail++; $display("FAIL gated_latency got %0d want 1", last_load_cen - acc);
        end
        cen_div = 1;
        step(); step(); step();
    endtask

`ifdef JT51_RING_RDBACK_EN
    task automatic test_readback();
        wait_slot(0, 1);
        do_write(5'd9, 5'h0A);
        wr_valid = 1'b0;
        wait_drain();
        rd_slot = 5'd9; rd_req = 1'b1; rd_q.push_back(5'h0A);
        step();
        rd_req = 1'b0;
        ntests++; if (rd_busy !== 1) begin nfail++; $display("FAIL rd_busy got %b want 1", rd_busy); end
        // request while busy must be ignored (slot 3 holds 15)
        rd_slot = 5'd3; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        wait_rd();
        step();
        ntests++; if (rd_busy !== 0) begin nfail++; $display("FAIL rd_busy_clear got %b want 0", rd_busy); end
        // simultaneous load and capture of slot 9 returns the old value
        wait_slot(5'd12, 0);
        do_write(5'd9, 5'h11);
        wr_valid = 1'b0;
        rd_slot = 5'd9; rd_req = 1'b1; rd_q.push_back(5'h0A);
        step();
        rd_req = 1'b0;
        wait_rd();
        wait_drain();
        step();
        rd_slot = 5'd9; rd_req = 1'b1; rd_q.push_back(5'h11);
        step();
        rd_req = 1'b0;
        wait_rd();
        step();
    endtask
`else
    task automatic test_readback();
        int bad = 0;
        rd_slot = 5'd3; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (rd_busy !== 0 || rd_valid !== 0 || rd_data !== 0) bad++;
            step();
        end
        ntests++;
        if (bad != 0) begin nfail++; $display("FAIL rd_disabled got %0d active cycles want 0", bad); end
    endtask
`endif

    task automatic test_reset_mid();
        int lc, diff;
        logic [WIDTH-1:0] snap [STAGES];
        wait_slot(5'd20, 0);
        do_write(5'd5, 5'h1A);
        do_write(5'd6, 5'h1B);
        do_write(5'd7, 5'h1C);
        wr_valid = 1'b0;
        lc = load_cnt;
        rst = 1'b1;
        exp_q.delete();
        #1;
        for (int i = 0; i < STAGES; i++) snap[i] = ring[i];
        ntests++; if (slot !== 0)     begin nfail++; $display("FAIL mid_rst_slot got %0d want 0", slot); end
        ntests++; if (wr_ready !== 1) begin nfail++; $display("FAIL mid_rst_ready got %b want 1", wr_ready); end
        step(); step();
        rst = 1'b0;
        ntests++; if (slot !== 0)     begin nfail++; $display("FAIL mid_rel_slot got %0d want 0", slot); end
        ntests++; if (wr_ready !== 1) begin nfail++; $display("FAIL mid_rel_ready got %b want 1", wr_ready); end
        repeat (2 * STAGES) step();
        ntests++; if (load_cnt !== lc) begin nfail++; $display("FAIL mid_no_load got %0d loads want 0", load_cnt - lc); end
        diff = 0;
        for (int i = 0; i < STAGES; i++) if (ring[i] !== snap[i]) diff++;
        ntests++; if (diff != 0) begin nfail++; $display("FAIL mid_ring_kept got %0d changed want 0", diff); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_same_slot();
        test_cen_gating();
        test_readback();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
